// File: rtl/nes_palette_ctrl.sv
// Palette RAM controller: video lookups own the single RAM port, uploads fill the idle cycles.
// Latency: pixel valid 2 cycles after pix_ce_n; an accepted entry is written 1-2 cycles after its odd byte.
// Backpressure: load_ready drops while a built entry waits for a free RAM cycle (at most 1 stall cycle).
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   pix_ce_n, color -> pixel     per-pixel lookup (strobe is active high despite its name)
//   load_start/valid/addr/data/done, load_ready   HPS upload byte stream (entry = addr[6:1], byte = addr[0])
//   use_custom, load_err         custom palette complete / sticky dropped-byte or incomplete-upload flag
//   ram_addr/we/wdata/rdata      single-port synchronous RAM, 1-cycle read latency
// Optional feature macro PALETTE_READBACK_EN adds rb_req/rb_addr/rb_ack/rb_data so the HPS can read
// entries back; it gets the RAM only when neither video nor a pending write wants it.
module nes_palette_ctrl #(
    parameter int ENTRIES = 64,
    parameter int CW      = 15,
    localparam int AW     = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce_n,
    input  logic [AW-1:0] color,
    output logic [CW-1:0] pixel,
    input  logic          load_start,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW:0]   load_addr,
    input  logic [7:0]    load_data,
    input  logic          load_done,
    output logic          use_custom,
    output logic          load_err,
`ifdef PALETTE_READBACK_EN
    input  logic          rb_req,
    input  logic [AW-1:0] rb_addr,
    output logic          rb_ack,
    output logic [CW-1:0] rb_data,
`endif
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [CW-1:0] ram_wdata,
    input  logic [CW-1:0] ram_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;   // waiting for a low byte
    localparam logic [1:0] S_LOW  = 2'd1;   // low byte held, waiting for its high byte
    localparam logic [1:0] S_PEND = 2'd2;   // full word built, waiting for a RAM cycle

    logic [1:0]         state;
    logic [AW-1:0]      wr_idx;
    logic [7:0]         low_byte;
    logic [CW-1:0]      wr_word;
    logic [ENTRIES-1:0] mask;
    logic               done_pend;
    logic               vid_d;

    logic               xfer;
    logic               odd_byte;
    logic               same_entry;
    logic               wr_go;
    logic               done_req;

    assign load_ready = (state != S_PEND);
    // load_start resets the upload, so a byte offered in the same cycle is not taken.
    assign xfer       = load_valid && load_ready && !load_start;
    assign odd_byte   = load_addr[0];
    assign same_entry = (load_addr[AW:1] == wr_idx);
    assign wr_go      = (state == S_PEND) && !pix_ce_n;
    assign done_req   = load_done || done_pend;
    assign ram_wdata  = wr_word;

`ifdef PALETTE_READBACK_EN
    logic rb_busy;
    logic rb_d1;
    logic rb_issue;

    // Lowest priority: only when video is quiet and no built entry is waiting.
    assign rb_issue = rb_req && !rb_busy && !pix_ce_n && (state != S_PEND);
`endif

    // RAM port arbitration: video > pending write (> readback).
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        if (pix_ce_n) begin
            ram_addr = color;
        end else if (wr_go) begin
            ram_we   = 1'b1;
            ram_addr = wr_idx;
        end
`ifdef PALETTE_READBACK_EN
        else if (rb_issue) begin
            ram_addr = rb_addr;
        end
`endif
    end

    // Read data is valid the cycle after the strobe; capture it then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_d <= 1'b0;
            pixel <= '0;
        end else begin
            vid_d <= pix_ce_n;
            if (vid_d) begin
                pixel <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_idx     <= '0;
            low_byte   <= '0;
            wr_word    <= '0;
            mask       <= '0;
            done_pend  <= 1'b0;
            use_custom <= 1'b0;
            load_err   <= 1'b0;
        end else if (load_start) begin
            state      <= S_IDLE;
            mask       <= '0;
            done_pend  <= 1'b0;
            use_custom <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (!odd_byte) begin
                            low_byte <= load_data;
                            wr_idx   <= load_addr[AW:1];
                            state    <= S_LOW;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    if (xfer) begin
                        if (!odd_byte) begin
                            // A second low byte supersedes the first; the first is lost.
                            low_byte <= load_data;
                            wr_idx   <= load_addr[AW:1];
                            load_err <= 1'b1;
                        end else if (same_entry) begin
                            // Top bit of the high byte has no home in a 15-bit colour.
                            wr_word <= {load_data[CW-9:0], low_byte};
                            state   <= S_PEND;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_PEND: begin
                    if (!pix_ce_n) begin
                        mask[wr_idx] <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A done arriving while a write is pending waits for that write to land in the mask.
            if (done_req) begin
                if (state == S_PEND) begin
                    done_pend <= 1'b1;
                end else begin
                    done_pend <= 1'b0;
                    if (&mask) begin
                        use_custom <= 1'b1;
                    end else begin
                        use_custom <= 1'b0;
                        load_err   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef PALETTE_READBACK_EN
    // Issue -> RAM data next cycle -> registered ack/data the cycle after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_busy <= 1'b0;
            rb_d1   <= 1'b0;
            rb_ack  <= 1'b0;
            rb_data <= '0;
        end else begin
            rb_d1  <= rb_issue;
            rb_ack <= rb_d1;
            if (rb_d1) begin
                rb_data <= ram_rdata;
            end
            if (rb_issue) begin
                rb_busy <= 1'b1;
            end else if (rb_ack) begin
                rb_busy <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nes_palette_ctrl.sv
module tb_nes_palette_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce_n;
    logic [5:0]  color;
    logic [14:0] pixel;
    logic        load_start, load_valid, load_ready, load_done;
    logic [6:0]  load_addr;
    logic [7:0]  load_data;
    logic        use_custom, load_err;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [14:0] ram_wdata;
    logic [14:0] ram_rdata;
`ifdef PALETTE_READBACK_EN
    logic        rb_req, rb_ack;
    logic [5:0]  rb_addr;
    logic [14:0] rb_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nes_palette_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pix_ce_n   (pix_ce_n),
        .color      (color),
        .pixel      (pixel),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .use_custom (use_custom),
        .load_err   (load_err),
`ifdef PALETTE_READBACK_EN
        .rb_req     (rb_req),
        .rb_addr    (rb_addr),
        .rb_ack     (rb_ack),
        .rb_data    (rb_data),
`endif
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Synchronous single-port RAM with a bench-side preload path.
    logic [14:0] mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_addr;
    logic [14:0] pl_data;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pl_we) mem[pl_addr] <= pl_data;
        ram_rdata <= mem[ram_addr];
    end

    // Scoreboard and write log.
    logic [14:0] sb_q[$];
    logic [1:0]  hist = 2'b00;
    int          wr_count = 0;
    logic [5:0]  last_wa;
    logic [14:0] last_wd;
    int          gcnt = 0;
    logic        lk_en = 1'b0;
    logic [5:0]  lk_col;
    logic [14:0] lk_exp;

    function automatic logic [14:0] f_val(input int e);
        return 15'((e * 693 + 4951) ^ (e << 9));
    endfunction

    function automatic logic [14:0] g_val(input int e);
        return 15'((e * 273) ^ 10922);
    endfunction

    // One clock: entered and left at the falling edge, after the pixel scoreboard has run.
    task automatic tick();
        logic [14:0] exp_px;
        #1;
        if (pix_ce_n) begin
            checks++;
            if (ram_we !== 1'b0 || ram_addr !== color) begin
                failures++;
                $display("FAIL video_prio: ram_we=%b ram_addr=%0d, required ram_we=0 ram_addr=%0d", ram_we, ram_addr, color);
            end
        end
        if (ram_we === 1'b1) begin
            wr_count++;
            last_wa = ram_addr;
            last_wd = ram_wdata;
        end
        hist = {hist[0], pix_ce_n};
        @(posedge clk);
        @(negedge clk);
        if (hist[1]) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_sb: pixel=%h with no expected lookup", pixel);
            end else begin
                exp_px = sb_q.pop_front();
                if (pixel !== exp_px) begin
                    failures++;
                    $display("FAIL pixel_sb: pixel=%h, required %h", pixel, exp_px);
                end
            end
        end
    endtask

    task automatic preload_one(input logic [5:0] a, input logic [14:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] c, input logic [14:0] e);
        pix_ce_n = 1'b1; color = c; sb_q.push_back(e);
        tick();
        pix_ce_n = 1'b0;
        tick();
    endtask

    task automatic drive_pix();
        if (lk_en && (gcnt % 8 == 0)) begin
            pix_ce_n = 1'b1; color = lk_col; sb_q.push_back(lk_exp);
        end else begin
            pix_ce_n = 1'b0;
        end
    endtask

    // Offers one byte until it is accepted; returns in the cycle after acceptance.
    task automatic send_byte(input logic [6:0] a, input logic [7:0] d);
        int   guard;
        logic rdy;
        guard = 0;
        load_valid = 1'b1; load_addr = a; load_data = d;
        do begin
            drive_pix();
            rdy = load_ready;
            tick();
            gcnt++;
            guard++;
        end while (!rdy && guard < 20);
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL send_timeout: byte addr %0d not accepted in %0d cycles", a, guard);
        end
        load_valid = 1'b0;
        pix_ce_n   = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks += 6;
        if (pixel !== 15'h0)    begin failures++; $display("FAIL rst_pixel: %h, required 0", pixel); end
        if (use_custom !== 1'b0) begin failures++; $display("FAIL rst_use_custom: %b, required 0", use_custom); end
        if (load_err !== 1'b0)  begin failures++; $display("FAIL rst_load_err: %b, required 0", load_err); end
        if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_load_ready: %b, required 1", load_ready); end
        if (ram_we !== 1'b0)    begin failures++; $display("FAIL rst_ram_we: %b, required 0", ram_we); end
        if (ram_addr !== 6'd0)  begin failures++; $display("FAIL rst_ram_addr: %0d, required 0", ram_addr); end
        reset = 1'b0;
        tick();
        checks += 2;
        if (load_ready !== 1'b1 || ram_we !== 1'b0) begin
            failures++; $display("FAIL post_rst_idle: load_ready=%b ram_we=%b, required 1/0", load_ready, ram_we);
        end
        if (ram_addr !== 6'd0) begin failures++; $display("FAIL post_rst_addr: %0d, required 0", ram_addr); end
    endtask

    task automatic test_lookup();
        for (int e = 0; e < 64; e++) preload_one(6'(e), g_val(e));
        preload_one(6'd5, 15'h1234);
        preload_one(6'd9, 15'h7fff);
        preload_one(6'd0, 15'h0001);
        pix_ce_n = 1'b1; color = 6'd5; sb_q.push_back(15'h1234);
        tick();
        pix_ce_n = 1'b0;
        checks += 2;
        if (pixel !== 15'h0) begin failures++; $display("FAIL lookup_early: pixel=%h one cycle after strobe, required 0", pixel); end
        if (load_ready !== 1'b1 || use_custom !== 1'b0) begin
            failures++; $display("FAIL lookup_flags: load_ready=%b use_custom=%b, required 1/0", load_ready, use_custom);
        end
        tick();
        lookup(6'd9, 15'h7fff);
        lookup(6'd0, 15'h0001);
        lookup(6'd40, g_val(40));
        lookup(6'd5, 15'h1234);
        checks++;
        if (load_ready !== 1'b1 || use_custom !== 1'b0) begin
            failures++; $display("FAIL lookup_flags_end: load_ready=%b use_custom=%b, required 1/0", load_ready, use_custom);
        end
    endtask

    task automatic test_deferred_write();
        preload_one(6'd5, 15'h0000);
        preload_one(6'd7, 15'h0abc);
        pulse_start();
        send_byte(7'd10, 8'h34);
        send_byte(7'd11, 8'h92);
        // PEND cycle, video strobe takes the port.
        pix_ce_n = 1'b1; color = 6'd7; sb_q.push_back(15'h0abc);
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL defer_ready: %b in PEND, required 0", load_ready); end
        tick();
        pix_ce_n = 1'b0;
        #1;
        checks += 2;
        if (ram_we !== 1'b1 || ram_addr !== 6'd5) begin
            failures++; $display("FAIL defer_write: ram_we=%b ram_addr=%0d, required 1/5", ram_we, ram_addr);
        end
        if (ram_wdata !== 15'h1234) begin failures++; $display("FAIL defer_wdata: %h, required 1234", ram_wdata); end
        tick();
        checks++;
        if (load_ready !== 1'b1 || ram_we !== 1'b0) begin
            failures++; $display("FAIL defer_after: load_ready=%b ram_we=%b, required 1/0", load_ready, ram_we);
        end
        lookup(6'd5, 15'h1234);
    endtask

    task automatic test_full_upload();
        logic [14:0] v;
        pulse_start();
        for (int e = 0; e < 64; e++) begin
            lk_en  = (e != 63);
            lk_col = (e < 32) ? 6'(e + 32) : 6'(e - 32);
            lk_exp = (e < 32) ? g_val(e + 32) : f_val(e - 32);
            v = f_val(e);
            send_byte(7'(2 * e), v[7:0]);
            send_byte(7'(2 * e + 1), {1'($urandom_range(0, 1)), v[14:8]});
        end
        lk_en = 1'b0;
        // load_done collides with a write that video is holding off.
        pix_ce_n = 1'b1; color = 6'd0; sb_q.push_back(f_val(0));
        load_done = 1'b1;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL full_pend: load_ready=%b, required 0", load_ready); end
        tick();
        load_done = 1'b0; pix_ce_n = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 6'd63) begin
            failures++; $display("FAIL full_last_write: ram_we=%b ram_addr=%0d, required 1/63", ram_we, ram_addr);
        end
        tick();
        checks++;
        if (use_custom !== 1'b0) begin failures++; $display("FAIL full_uc_early: %b, required 0", use_custom); end
        tick();
        checks += 2;
        if (use_custom !== 1'b1) begin failures++; $display("FAIL full_uc: %b, required 1", use_custom); end
        if (load_err !== 1'b0) begin failures++; $display("FAIL full_err: %b, required 0", load_err); end
        for (int e = 0; e < 64; e++) lookup(6'(e), f_val(e));
    endtask

    task automatic test_partial_upload();
        logic [14:0] v;
        pulse_start();
        checks++;
        if (use_custom !== 1'b0) begin failures++; $display("FAIL start_clears_uc: %b, required 0", use_custom); end
        for (int e = 0; e < 63; e++) begin
            v = f_val(e) ^ 15'h5555;
            send_byte(7'(2 * e), v[7:0]);
            send_byte(7'(2 * e + 1), {1'b0, v[14:8]});
        end
        tick(); tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        checks += 2;
        if (use_custom !== 1'b0) begin failures++; $display("FAIL partial_uc: %b, required 0", use_custom); end
        if (load_err !== 1'b1) begin failures++; $display("FAIL partial_err: %b, required 1", load_err); end
    endtask

    task automatic test_drop();
        int w0;
        pulse_start();
        checks++;
        if (load_err !== 1'b0) begin failures++; $display("FAIL start_clears_err: %b, required 0", load_err); end
        w0 = wr_count;
        send_byte(7'd21, 8'haa);
        checks++;
        if (load_err !== 1'b1) begin failures++; $display("FAIL drop_odd_first: load_err=%b, required 1", load_err); end
        send_byte(7'd20, 8'h55);
        send_byte(7'd23, 8'h66);
        tick();
        // Would complete entry 10 if the FSM had wrongly stayed holding it.
        send_byte(7'd21, 8'h77);
        tick(); tick(); tick();
        checks++;
        if (wr_count !== w0) begin failures++; $display("FAIL drop_no_write: %0d writes, required 0", wr_count - w0); end
        pulse_start();
        checks++;
        if (load_err !== 1'b0) begin failures++; $display("FAIL drop_start_clears: load_err=%b, required 0", load_err); end
        send_byte(7'd40, 8'h11);
        send_byte(7'd42, 8'h22);
        checks++;
        if (load_err !== 1'b1) begin failures++; $display("FAIL replace_err: load_err=%b, required 1", load_err); end
        send_byte(7'd43, 8'h33);
        tick(); tick();
        checks += 2;
        if (wr_count !== w0 + 1) begin failures++; $display("FAIL replace_count: %0d writes, required 1", wr_count - w0); end
        if (last_wa !== 6'd21 || last_wd !== 15'h3322) begin
            failures++; $display("FAIL replace_word: entry %0d data %h, required 21/3322", last_wa, last_wd);
        end
    endtask

    task automatic test_reset_pend();
        int w0;
        pulse_start();
        w0 = wr_count;
        send_byte(7'd10, 8'h34);
        send_byte(7'd11, 8'h56);
        reset = 1'b1;
        #1;
        checks += 3;
        if (ram_we !== 1'b0) begin failures++; $display("FAIL rpend_we: %b, required 0", ram_we); end
        if (load_ready !== 1'b1) begin failures++; $display("FAIL rpend_ready: %b, required 1", load_ready); end
        if (use_custom !== 1'b0 || pixel !== 15'h0) begin
            failures++; $display("FAIL rpend_outs: use_custom=%b pixel=%h, required 0/0", use_custom, pixel);
        end
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (wr_count !== w0 || load_ready !== 1'b1) begin
            failures++; $display("FAIL rpend_after: writes=%0d load_ready=%b, required 0/1", wr_count - w0, load_ready);
        end
    endtask

`ifdef PALETTE_READBACK_EN
    task automatic test_readback();
        int k;
        preload_one(6'd5, 15'h1234);
        rb_req = 1'b1; rb_addr = 6'd5;
        k = 0;
        while (!rb_ack && k < 6) begin
            tick();
            k++;
        end
        checks += 2;
        if (k !== 2) begin failures++; $display("FAIL rb_latency: ack after %0d cycles, required 2", k); end
        if (rb_data !== 15'h1234) begin failures++; $display("FAIL rb_data: %h, required 1234", rb_data); end
        tick();
        rb_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; pix_ce_n = 1'b0; color = '0;
        load_start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
`ifdef PALETTE_READBACK_EN
        rb_req = 1'b0; rb_addr = '0;
`endif
        @(negedge clk);
        test_reset();
        test_lookup();
        test_deferred_write();
        test_full_upload();
        test_partial_upload();
        test_drop();
        test_reset_pend();
`ifdef PALETTE_READBACK_EN
        test_readback();
`endif
        tick(); tick(); tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL sb_drain: %0d lookups without output, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
